// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl: sequencer in front of the moving-average filter.
// Accepts mode-change requests, drives the filter's filt_sel and sclr, and
// mutes the filtered stream until the delay line holds valid history again.
module filter_mode_ctrl #(
  parameter int         BIT_WIDTH    = 16,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] INIT_MODE    = 2'b00,
  parameter int         PIPE_LAT     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           i_mode_req,
  input  logic                 i_mode_req_valid,
  output logic                 o_mode_req_ready,
  input  logic                 i_flush_req,
  output logic [1:0]           o_filt_sel,
  output logic                 o_sclr,
  input  logic [BIT_WIDTH-1:0] i_q_in,
  output logic [BIT_WIDTH-1:0] o_q_out,
  output logic                 o_mute,
  output logic                 o_mode_done
);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

  // Settle length minus one: history taps of the selected mode plus the
  // filter's output pipeline, so the first unmuted sample is fully valid.
  function automatic logic [7:0] settle_load(input logic [1:0] mode);
    int hist;
    case (mode)
      2'b00:   hist = 0;
      2'b01:   hist = 1;
      2'b10:   hist = 3;
      default: hist = 7;
    endcase
    return 8'(hist + PIPE_LAT - 1);
  endfunction

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_filt_sel;
  logic       r_pend;      // current sequence began with an accepted request
  logic       r_sclr;
  logic       r_mute;
  logic       r_ready;
  logic       r_done;
  logic [BIT_WIDTH-1:0] r_q_out;

  state_t     w_next_state;
  logic [7:0] w_next_cnt;
  logic [1:0] w_next_sel;
  logic       w_next_pend;
  logic       w_next_done;
  logic       w_accept;

  assign w_accept = i_mode_req_valid & r_ready;

  // Next-state decode; every output register is loaded from this decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_sel   = r_filt_sel;
    w_next_pend  = r_pend;
    w_next_done  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          if ((i_mode_req != r_filt_sel) || i_flush_req) begin
            // A simultaneous flush_req folds into the one mode flush.
            w_next_state = ST_FLUSH;
            w_next_cnt   = FLUSH_LOAD;
            w_next_sel   = i_mode_req;
            w_next_pend  = 1'b1;
          end else begin
            w_next_done  = 1'b1;
          end
        end else if (i_flush_req) begin
          w_next_state = ST_FLUSH;
          w_next_cnt   = FLUSH_LOAD;
          w_next_pend  = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (i_flush_req) begin
          w_next_cnt = FLUSH_LOAD;
        end else if (r_cnt == 8'd0) begin
          w_next_state = ST_SETTLE;
          w_next_cnt   = settle_load(r_filt_sel);
        end else begin
          w_next_cnt = r_cnt - 8'd1;
        end
      end
      ST_SETTLE: begin
        if (i_flush_req) begin
          w_next_state = ST_FLUSH;
          w_next_cnt   = FLUSH_LOAD;
        end else if (r_cnt == 8'd0) begin
          w_next_state = ST_RUN;
          w_next_done  = r_pend;
          w_next_pend  = 1'b0;
        end else begin
          w_next_cnt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_next_state = ST_FLUSH;
        w_next_cnt   = FLUSH_LOAD;
        w_next_pend  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset starts the initial flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FLUSH;
      r_cnt      <= FLUSH_LOAD;
      r_filt_sel <= INIT_MODE;
      r_pend     <= 1'b0;
      r_sclr     <= 1'b1;
      r_mute     <= 1'b1;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_q_out    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_filt_sel <= w_next_sel;
      r_pend     <= w_next_pend;
      r_sclr     <= (w_next_state == ST_FLUSH);
      r_mute     <= (w_next_state != ST_RUN);
      r_ready    <= (w_next_state == ST_RUN);
      r_done     <= w_next_done;
      r_q_out    <= (w_next_state == ST_RUN) ? i_q_in : '0;
    end
  end

  assign o_mode_req_ready = r_ready;
  assign o_filt_sel       = r_filt_sel;
  assign o_sclr           = r_sclr;
  assign o_mute           = r_mute;
  assign o_mode_done      = r_done;
  assign o_q_out          = r_q_out;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// tb_filter_mode_ctrl: directed vectors for filter_mode_ctrl with default
// parameters (FLUSH_CYCLES=2, PIPE_LAT=2, INIT_MODE=00).
module tb_filter_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_req;
  logic        mode_req_valid;
  logic        mode_req_ready;
  logic        flush_req;
  logic [1:0]  filt_sel;
  logic        sclr;
  logic [15:0] q_in;
  logic [15:0] q_out;
  logic        mute;
  logic        mode_done;

  int n_tests = 0;
  int n_fail  = 0;

  filter_mode_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_mode_req       (mode_req),
    .i_mode_req_valid (mode_req_valid),
    .o_mode_req_ready (mode_req_ready),
    .i_flush_req      (flush_req),
    .o_filt_sel       (filt_sel),
    .o_sclr           (sclr),
    .i_q_in           (q_in),
    .o_q_out          (q_out),
    .o_mute           (mute),
    .o_mode_done      (mode_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic e_sclr, input logic e_mute,
                            input logic e_ready, input logic e_done,
                            input logic [1:0] e_sel, input logic [15:0] e_q);
    check({tag, ".sclr"},  32'(sclr),           32'(e_sclr));
    check({tag, ".mute"},  32'(mute),           32'(e_mute));
    check({tag, ".ready"}, 32'(mode_req_ready), 32'(e_ready));
    check({tag, ".done"},  32'(mode_done),      32'(e_done));
    check({tag, ".sel"},   32'(filt_sel),       32'(e_sel));
    check({tag, ".q"},     32'(q_out),          32'(e_q));
  endtask

  // Called in the first FLUSH cycle: expects n_flush sclr cycles, n_settle
  // muted settle cycles, then the first RUN cycle with q_in passed through.
  task automatic run_seq(input string tag, input int n_flush, input int n_settle,
                         input logic e_done, input logic [1:0] e_sel);
    for (int i = 0; i < n_flush; i++) begin
      check_outs({tag, ".flush"}, 1'b1, 1'b1, 1'b0, 1'b0, e_sel, 16'h0000);
      tick();
    end
    for (int i = 0; i < n_settle; i++) begin
      check_outs({tag, ".settle"}, 1'b0, 1'b1, 1'b0, 1'b0, e_sel, 16'h0000);
      tick();
    end
    check_outs({tag, ".run"}, 1'b0, 1'b0, 1'b1, e_done, e_sel, q_in);
  endtask

  initial begin
    rst_n          = 1'b0;
    mode_req       = 2'b00;
    mode_req_valid = 1'b0;
    flush_req      = 1'b0;
    q_in           = 16'h1234;

    // 1: reset values, then initial flush of mode 00 (2 sclr, 4 mute cycles).
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    rst_n = 1'b1;
    run_seq("init", 2, 2, 1'b0, 2'b00);

    // Pass-through in RUN for several sample patterns.
    q_in = 16'hA5A5; tick(); check("pass_a5a5", 32'(q_out), 32'h0000_A5A5);
    q_in = 16'hFFFF; tick(); check("pass_ffff", 32'(q_out), 32'h0000_FFFF);
    q_in = 16'h0001; tick(); check("pass_0001", 32'(q_out), 32'h0000_0001);
    check("pass_done", 32'(mode_done), 32'h0);

    // 2: mode 11 requested for one cycle: 2 flush + 9 settle, then mode_done.
    q_in = 16'hBEEF;
    mode_req = 2'b11; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    run_seq("m11", 2, 9, 1'b1, 2'b11);
    tick();
    check("m11_done_1cyc", 32'(mode_done), 32'h0);

    // 3: move to mode 10 (settle 5), then re-request 10: no flush, done next cycle.
    mode_req = 2'b10; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    run_seq("m10", 2, 5, 1'b1, 2'b10);
    tick();
    mode_req = 2'b10; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    check_outs("same", 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 16'hBEEF);
    tick();
    check("same_done_1cyc", 32'(mode_done), 32'h0);

    // 4: flush_req in 3rd SETTLE cycle of mode 11 restarts flush and settle.
    mode_req = 2'b11; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_outs("restart.flush", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0000);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check_outs("restart.settle", 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0000);
      tick();
    end
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    run_seq("restart", 2, 9, 1'b1, 2'b11);
    tick();

    // 5: request held during a flush_req-only sequence is accepted in first RUN cycle.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    mode_req = 2'b01; mode_req_valid = 1'b1;
    run_seq("held", 2, 9, 1'b0, 2'b11);
    tick();
    mode_req_valid = 1'b0;
    run_seq("held_acc", 2, 3, 1'b1, 2'b01);
    tick();

    // Same-mode accept with flush_req: exactly one flush, mode_done at the end.
    mode_req = 2'b01; mode_req_valid = 1'b1; flush_req = 1'b1;
    tick();
    mode_req_valid = 1'b0; flush_req = 1'b0;
    run_seq("acc_flush", 2, 3, 1'b1, 2'b01);
    tick();

    // 6: async reset in the middle of a mode-11 settle.
    mode_req = 2'b11; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_outs("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0000);
    #1 rst_n = 1'b0;
    #1 check_outs("async_rst", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("rerun", 2, 2, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
